finger_code_encoder: RTL and testbench

FINGER_CODE_ENCODER -- requirements
Module: finger_code_encoder

---
 rtl/finger_enc_pkg.sv | 29 ++
 rtl/code_fifo.sv | 54 +++++
 rtl/finger_code_encoder.sv | 109 ++++++++++
 tb/tb_finger_code_encoder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/finger_enc_pkg.sv
// rtl/finger_enc_pkg.sv - shared types and pattern table for the finger code encoder
package finger_enc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  typedef logic [1:0] code_t;

  localparam logic [3:0] PAT_00 = 4'b0000;
  localparam logic [3:0] PAT_01 = 4'b1110;
  localparam logic [3:0] PAT_10 = 4'b1100;
  localparam logic [3:0] PAT_11 = 4'b1111;

  // Patterns are chosen so Y0=A&B&C and Y1=A&B&(C xnor D) recover the code.
  function automatic logic [3:0] code_to_pat(input code_t code);
    logic [3:0] pat;
    case (code)
      2'b01:   pat = PAT_01;
      2'b10:   pat = PAT_10;
      2'b11:   pat = PAT_11;
      default: pat = PAT_00;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/code_fifo.sv
// rtl/code_fifo.sv - synchronous FIFO buffering accepted codes
module code_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/finger_code_encoder.sv
// rtl/finger_code_encoder.sv - drives buffered 2-bit codes as timed ABCD finger patterns
module finger_code_encoder
  import finger_enc_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] in_code,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       pat_valid,
  output logic       busy
);

  localparam int MAXP = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXP) + 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t                      state;
  logic [CW-1:0]               cnt;
  logic [3:0]                  pat;
  code_t                       fifo_rdata;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        push;
  logic                        pop;
  logic                        hold_done;
  logic                        gap_done;

  assign in_ready  = !rst && !fifo_full;
  assign push      = in_valid && in_ready;
  assign hold_done = (state == HOLD) && (cnt == HOLD_LAST);
  assign gap_done  = (state == GAP) && (cnt == GAP_LAST);
  assign pop       = !fifo_empty &&
                     ((state == IDLE) || (hold_done && GAP_CYCLES == 0) || gap_done);
  assign busy      = (state != IDLE) || (fifo_count != '0);
  assign {A, B, C, D} = pat;

  code_fifo #(
    .WIDTH (2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (in_code),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A pop always starts a fresh HOLD, whichever state it is taken from.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      pat       <= PAT_00;
      pat_valid <= 1'b0;
    end else if (pop) begin
      state     <= HOLD;
      cnt       <= '0;
      pat       <= code_to_pat(fifo_rdata);
      pat_valid <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          pat       <= PAT_00;
          pat_valid <= 1'b0;
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            state     <= (GAP_CYCLES > 0) ? GAP : IDLE;
            cnt       <= '0;
            pat       <= PAT_00;
            pat_valid <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          pat       <= PAT_00;
          pat_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_finger_code_encoder.sv
// tb/tb_finger_code_encoder.sv - directed scoreboard bench for finger_code_encoder
module tb_finger_code_encoder;

  logic       clk = 1'b0;
  logic       rst0, rst1;
  logic [1:0] in_code0, in_code1;
  logic       in_valid0, in_valid1;
  logic       in_ready0, in_ready1;
  logic       a0, b0, c0, d0, pv0, busy0;
  logic       a1, b1, c1, d1, pv1, busy1;
  logic [3:0] abcd0, abcd1;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [1:0] sb [$];
  int         mon_len = 0;

  always #5 clk = ~clk;

  assign abcd0 = {a0, b0, c0, d0};
  assign abcd1 = {a1, b1, c1, d1};

  finger_code_encoder u_dut0 (
    .clk(clk), .rst(rst0), .in_code(in_code0), .in_valid(in_valid0), .in_ready(in_ready0),
    .A(a0), .B(b0), .C(c0), .D(d0), .pat_valid(pv0), .busy(busy0)
  );

  finger_code_encoder #(.HOLD_CYCLES(1), .GAP_CYCLES(0), .FIFO_DEPTH(4)) u_dut1 (
    .clk(clk), .rst(rst1), .in_code(in_code1), .in_valid(in_valid1), .in_ready(in_ready1),
    .A(a1), .B(b1), .C(c1), .D(d1), .pat_valid(pv1), .busy(busy1)
  );

  function automatic logic [3:0] exp_pat(input logic [1:0] code);
    case (code)
      2'b01:   return 4'b1110;
      2'b10:   return 4'b1100;
      2'b11:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [1:0] decode(input logic [3:0] p);
    return {p[3] & p[2] & (p[1] ~^ p[0]), p[3] & p[2] & p[1]};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int inst, input logic [1:0] code, input logic exp_ready);
    @(negedge clk);
    if (inst == 0) begin
      in_code0  = code;
      in_valid0 = 1'b1;
      chk("in_ready0", 8'(in_ready0), 8'(exp_ready));
      if (exp_ready) sb.push_back(code);
    end else begin
      in_code1  = code;
      in_valid1 = 1'b1;
      chk("in_ready1", 8'(in_ready1), 8'(exp_ready));
    end
    step();
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
  endtask

  task automatic wait_idle0(input int budget);
    int n = 0;
    while (busy0 && n < budget) begin
      step();
      n++;
    end
    chk("idle_timeout", 8'(busy0), 8'd0);
  endtask

  // Scoreboard side: each new pattern on instance 0 consumes the oldest accepted code.
  always @(negedge clk) begin
    if (rst0) begin
      mon_len = 0;
    end else if (pv0) begin
      if (mon_len == 0) begin
        n_tests++;
        assert (sb.size() != 0) else begin
          n_fail++;
          $error("FAIL sb_unexpected: observed pattern %b expected none", abcd0);
        end
        if (sb.size() != 0) begin
          logic [1:0] e;
          e = sb.pop_front();
          chk("sb_decode", 8'(decode(abcd0)), 8'(e));
          chk("sb_pattern", 8'(abcd0), 8'(exp_pat(e)));
        end
      end
      mon_len++;
    end else begin
      if (mon_len != 0) chk("hold_len", 8'(mon_len), 8'd4);
      mon_len = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] burst_pats [4];
    int         rel, seg, pos;
    logic       exp_pv;
    logic       any_pv;

    burst_pats = '{4'b1110, 4'b1111, 4'b0000, 4'b1100};
    rst0 = 1'b1; rst1 = 1'b1;
    in_code0 = 2'b00; in_code1 = 2'b00;
    in_valid0 = 1'b0; in_valid1 = 1'b0;

    repeat (3) step();
    chk("rst_abcd", 8'(abcd0), 8'd0);
    chk("rst_pv", 8'(pv0), 8'd0);
    chk("rst_busy", 8'(busy0), 8'd0);
    chk("rst_ready", 8'(in_ready0), 8'd0);
    chk("rst_ready1", 8'(in_ready1), 8'd0);
    rst0 = 1'b0; rst1 = 1'b0;
    #1;
    chk("ready_after_rst", 8'(in_ready0), 8'd1);

    // Single code 10
    offer(0, 2'b10, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      step();
      exp_pv = (k <= 4);
      chk("single_abcd", 8'(abcd0), exp_pv ? 8'(4'b1100) : 8'd0);
      chk("single_pv", 8'(pv0), 8'(exp_pv));
      chk("single_busy", 8'(busy0), 8'(k <= 5));
    end

    // Back-to-back burst
    offer(0, 2'b01, 1'b1);
    offer(0, 2'b11, 1'b1);
    offer(0, 2'b00, 1'b1);
    offer(0, 2'b10, 1'b1);
    for (int t = 4; t <= 21; t++) begin
      step();
      rel = t - 1;
      seg = rel / 5;
      pos = rel % 5;
      exp_pv = (seg < 4) && (pos < 4);
      chk("burst_abcd", 8'(abcd0), exp_pv ? 8'(burst_pats[seg]) : 8'd0);
      chk("burst_pv", 8'(pv0), 8'(exp_pv));
    end
    chk("burst_idle", 8'(busy0), 8'd0);

    // Overfill while the first pattern is held
    offer(0, 2'b11, 1'b1);
    step();
    offer(0, 2'b00, 1'b1);
    offer(0, 2'b01, 1'b1);
    offer(0, 2'b10, 1'b1);
    offer(0, 2'b11, 1'b1);
    offer(0, 2'b01, 1'b0);
    wait_idle0(200);
    chk("overfill_sb_empty", 8'(sb.size()), 8'd0);

    // Reset in the second HOLD cycle of code 10 with three codes queued
    offer(0, 2'b01, 1'b1);
    offer(0, 2'b10, 1'b1);
    offer(0, 2'b11, 1'b1);
    offer(0, 2'b00, 1'b1);
    offer(0, 2'b01, 1'b1);
    repeat (3) step();
    chk("pre_rst_abcd", 8'(abcd0), 8'(4'b1100));
    chk("pre_rst_pv", 8'(pv0), 8'd1);
    rst0 = 1'b1;
    sb.delete();
    step();
    chk("midrst_abcd", 8'(abcd0), 8'd0);
    chk("midrst_pv", 8'(pv0), 8'd0);
    chk("midrst_busy", 8'(busy0), 8'd0);
    chk("midrst_ready", 8'(in_ready0), 8'd0);
    rst0 = 1'b0;
    any_pv = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step();
      any_pv = any_pv | pv0 | busy0;
    end
    chk("no_resume", 8'(any_pv), 8'd0);

    // HOLD_CYCLES=1, GAP_CYCLES=0 instance
    offer(1, 2'b11, 1'b1);
    offer(1, 2'b01, 1'b1);
    chk("g0_abcd_1", 8'(abcd1), 8'(4'b1111));
    chk("g0_pv_1", 8'(pv1), 8'd1);
    chk("g0_decode_1", 8'(decode(abcd1)), 8'(2'b11));
    step();
    chk("g0_abcd_2", 8'(abcd1), 8'(4'b1110));
    chk("g0_pv_2", 8'(pv1), 8'd1);
    chk("g0_decode_2", 8'(decode(abcd1)), 8'(2'b01));
    step();
    chk("g0_idle_pv", 8'(pv1), 8'd0);
    chk("g0_idle_busy", 8'(busy1), 8'd0);

    chk("final_sb_empty", 8'(sb.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
